// File: rtl/t_ff_toggle_sched_if.sv
// Requester-side bus of the T-FF toggle scheduler.
// Requesters (master) drive req/mask/rpt and observe gnt/busy/done/owner/q;
// the scheduler (slave) consumes the requests and drives the bank state.
interface t_ff_toggle_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RPTW  = 4
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ*RPTW-1:0]  rpt;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [OW-1:0]         owner;
  logic [WIDTH-1:0]      q;

  modport master (output req, mask, rpt, input gnt, busy, done, owner, q);
  modport slave  (input req, mask, rpt, output gnt, busy, done, owner, q);
endinterface

// File: rtl/t_ff_toggle_sched.sv
// Round-robin scheduler owning one bank of WIDTH T flip-flops shared by NREQ
// requesters. A granted job toggles its masked bits for rpt+1 consecutive
// edges, then frees the bank with a one-cycle done pulse.
// Ports: clk, rst (async, active-high); bus (slave modport): req/mask/rpt in,
//        gnt/busy/done/owner/q out.
// Optional: define TFF_SCHED_PRIO_EN to give requester 0 fixed top priority.
module t_ff_toggle_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RPTW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  t_ff_toggle_sched_if.slave  bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {IDLE, GRANT, TOGGLE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  job_mask_q, job_mask_d;
  logic [RPTW-1:0]   job_cnt_q, job_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  q_q, q_d;

  logic              found;
  logic [IW-1:0]     win;
  logic              ptr_upd;
  logic [CW-1:0]     cand;

  logic [WIDTH-1:0]  mask_a [NREQ];
  logic [RPTW-1:0]   rpt_a  [NREQ];

  // Split the flat request payloads into per-requester entries.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign mask_a[g] = bus.mask[g*WIDTH +: WIDTH];
    assign rpt_a[g]  = bus.rpt[g*RPTW +: RPTW];
  end

  // Arbiter: first requester found scanning upward from ptr+1 with wrap.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    ptr_upd = 1'b1;
    cand    = '0;
`ifdef TFF_SCHED_PRIO_EN
    // Requester 0 bypasses the rotation and leaves the pointer untouched.
    if (bus.req[0]) begin
      found   = 1'b1;
      win     = '0;
      ptr_upd = 1'b0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k + 1);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
`ifdef TFF_SCHED_PRIO_EN
      if (!found && (cand != '0) && bus.req[cand[IW-1:0]]) begin
`else
      if (!found && bus.req[cand[IW-1:0]]) begin
`endif
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    job_mask_d = job_mask_q;
    job_cnt_d  = job_cnt_q;
    gnt_d      = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    owner_d    = owner_q;
    q_d        = q_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          job_mask_d = mask_a[win];
          job_cnt_d  = rpt_a[win];
          gnt_d      = NREQ'(1) << win;
          owner_d    = win;
          if (ptr_upd) ptr_d = win;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        busy_d  = 1'b1;
        state_d = TOGGLE;
      end
      TOGGLE: begin
        q_d = q_q ^ job_mask_q;
        // Count reaching zero ends the job; it is never decremented past zero.
        if (job_cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          job_cnt_d = job_cnt_q - RPTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NREQ - 1);
      job_mask_q <= '0;
      job_cnt_q  <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      owner_q    <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      job_mask_q <= job_mask_d;
      job_cnt_q  <= job_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      owner_q    <= owner_d;
      q_q        <= q_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.owner = owner_q;
  assign bus.q     = q_q;
endmodule

// File: tb/tb_t_ff_toggle_sched.sv
// Directed bench for t_ff_toggle_sched: reset, single job, repeat counts,
// round-robin order, back-to-back jobs, reset mid-job, input changes mid-job
// and the maximum repeat count.
module tb_t_ff_toggle_sched;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned RPTW  = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total;
  logic [7:0] exp_q;
  int   exp_w;

  t_ff_toggle_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .RPTW(RPTW)) bus ();

  t_ff_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .RPTW(RPTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_job(input int i, input logic [7:0] m, input logic [3:0] r);
    bus.mask[i*WIDTH +: WIDTH] = m;
    bus.rpt[i*RPTW +: RPTW]    = r;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.mask = '0;
    bus.rpt  = '0;
    tick();
    tick();
    chk("rst_q",     32'(bus.q),     32'h0);
    chk("rst_gnt",   32'(bus.gnt),   32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_done",  32'(bus.done),  32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    rst = 1'b0;

    // Single job, rpt=0.
    set_job(0, 8'h0F, 4'd0);
    bus.req = 4'b0001;
    tick();
    chk("t1_gnt",   32'(bus.gnt),   32'h1);
    chk("t1_owner", 32'(bus.owner), 32'h0);
    chk("t1_busy0", 32'(bus.busy),  32'h0);
    bus.req = '0;
    tick();
    chk("t1_gnt_drop", 32'(bus.gnt),  32'h0);
    chk("t1_busy1",    32'(bus.busy), 32'h1);
    chk("t1_q_hold",   32'(bus.q),    32'h0);
    tick();
    chk("t1_q",     32'(bus.q),    32'h0F);
    chk("t1_done",  32'(bus.done), 32'h1);
    chk("t1_busy2", 32'(bus.busy), 32'h0);
    tick();
    chk("t1_done_end", 32'(bus.done), 32'h0);
    chk("t1_busy_end", 32'(bus.busy), 32'h0);

    // Repeat count 3: four toggles of bit 0.
    exp_q = 8'h0F;
    set_job(0, 8'h01, 4'd3);
    bus.req = 4'b0001;
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    chk("t2_busy", 32'(bus.busy), 32'h1);
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_q = exp_q ^ 8'h01;
      chk("t2_q",    32'(bus.q),    32'(exp_q));
      chk("t2_done", 32'(bus.done), 32'(t == 3));
      chk("t2_busy", 32'(bus.busy), 32'(t != 3));
    end
    tick();
    chk("t2_done_end", 32'(bus.done), 32'h0);

    // Round-robin with all four requesting.
    do_reset();
    exp_q = 8'h00;
    set_job(0, 8'h01, 4'd0);
    set_job(1, 8'h02, 4'd0);
    set_job(2, 8'h04, 4'd0);
    set_job(3, 8'h08, 4'd0);
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
`ifdef TFF_SCHED_PRIO_EN
      exp_w = 0;
`else
      exp_w = j % 4;
`endif
      tick();
      chk("t3_gnt",   32'(bus.gnt),   32'(1) << exp_w);
      chk("t3_owner", 32'(bus.owner), 32'(exp_w));
      chk("t3_done0", 32'(bus.done),  32'h0);
      if (j == 4) bus.req = '0;
      tick();
      chk("t3_busy", 32'(bus.busy), 32'h1);
      tick();
      exp_q = exp_q ^ (8'h01 << exp_w);
      chk("t3_q",    32'(bus.q),    32'(exp_q));
      chk("t3_done", 32'(bus.done), 32'h1);
    end
    tick();
    chk("t3_idle_gnt", 32'(bus.gnt), 32'h0);
`ifdef TFF_SCHED_PRIO_EN
    chk("t3_final_q", 32'(bus.q), 32'h01);
`else
    chk("t3_final_q", 32'(bus.q), 32'h0E);
`endif

    // Back-to-back: second grant on the edge done falls.
    do_reset();
    set_job(0, 8'h10, 4'd1);
    set_job(1, 8'h20, 4'd1);
    bus.req = 4'b0011;
    tick();
    chk("t4_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    tick();
    chk("t4_q1", 32'(bus.q), 32'h10);
    chk("t4_d1", 32'(bus.done), 32'h0);
    tick();
    chk("t4_q2",   32'(bus.q),    32'h00);
    chk("t4_done", 32'(bus.done), 32'h1);
    chk("t4_gnt_low", 32'(bus.gnt), 32'h0);
`ifdef TFF_SCHED_PRIO_EN
    exp_w = 0;
`else
    exp_w = 1;
`endif
    tick();
    chk("t4_gnt1",   32'(bus.gnt),  32'(1) << exp_w);
    chk("t4_done_f", 32'(bus.done), 32'h0);
    chk("t4_busy_g", 32'(bus.busy), 32'h0);
    bus.req = '0;
    tick();
    tick();
    chk("t4_q3", 32'(bus.q), (exp_w == 1) ? 32'h20 : 32'h10);
    tick();
    chk("t4_q4",    32'(bus.q),    32'h00);
    chk("t4_done2", 32'(bus.done), 32'h1);

    // Reset in the middle of a job.
    do_reset();
    set_job(2, 8'hFF, 4'd7);
    bus.req = 4'b0100;
    tick();
    chk("t5_gnt",   32'(bus.gnt),   32'h4);
    chk("t5_owner", 32'(bus.owner), 32'h2);
    bus.req = '0;
    tick();
    tick();
    chk("t5_q1", 32'(bus.q), 32'hFF);
    tick();
    chk("t5_q2", 32'(bus.q), 32'h00);
    tick();
    chk("t5_q3",   32'(bus.q),    32'hFF);
    chk("t5_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rst_q",    32'(bus.q),    32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    chk("t5_rst_gnt",  32'(bus.gnt),  32'h0);
    chk("t5_rst_done", 32'(bus.done), 32'h0);
    tick();
    chk("t5_rst_done2", 32'(bus.done), 32'h0);
    chk("t5_rst_q2",    32'(bus.q),    32'h0);
    rst = 1'b0;
    set_job(0, 8'h00, 4'd0);
    set_job(2, 8'hFF, 4'd0);
    set_job(3, 8'hF0, 4'd0);
    bus.req = 4'b1101;
    tick();
    chk("t5_post_gnt",   32'(bus.gnt),   32'h1);
    chk("t5_post_owner", 32'(bus.owner), 32'h0);
    bus.req = '0;
    tick();
    tick();
    chk("t5_mask0_q",    32'(bus.q),    32'h0);
    chk("t5_mask0_done", 32'(bus.done), 32'h1);
    tick();
    chk("t5_mask0_end", 32'(bus.done), 32'h0);

    // Mask change during a job has no effect.
    do_reset();
    set_job(1, 8'hAA, 4'd3);
    bus.req = 4'b0010;
    tick();
    chk("t6_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    tick();
    tick();
    chk("t6_q1", 32'(bus.q), 32'hAA);
    set_job(1, 8'h55, 4'd0);
    tick();
    chk("t6_q2",  32'(bus.q),    32'h00);
    chk("t6_d2",  32'(bus.done), 32'h0);
    tick();
    chk("t6_q3", 32'(bus.q), 32'hAA);
    tick();
    chk("t6_q4",   32'(bus.q),    32'h00);
    chk("t6_done", 32'(bus.done), 32'h1);

    // Maximum repeat count: 16 toggles, no counter wrap.
    do_reset();
    exp_q = 8'h00;
    set_job(0, 8'h01, 4'hF);
    bus.req = 4'b0001;
    tick();
    chk("t7_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    for (int t = 0; t < 16; t++) begin
      tick();
      exp_q = exp_q ^ 8'h01;
      chk("t7_q",    32'(bus.q),    32'(exp_q));
      chk("t7_done", 32'(bus.done), 32'(t == 15));
    end
    tick();
    chk("t7_busy_end", 32'(bus.busy), 32'h0);
    chk("t7_done_end", 32'(bus.done), 32'h0);
    chk("t7_q_end",    32'(bus.q),    32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/t_ff_toggle_sched.md
Name: t_ff_toggle_sched

Overview:
- Round-robin scheduler sharing one bank of WIDTH T flip-flops between NREQ requesters.
- Each request carries a toggle mask and a repeat count. Once granted, the block toggles the masked bits on consecutive clock edges for (rpt+1) cycles, then frees the bank.
- Sits between the control requesters and the T-FF bank. It is the only writer of the bank state.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of T flip-flops in the bank
- RPTW, 4, width of the per-requester repeat-count field

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level; hold high until granted
- mask  input  NREQ*WIDTH  toggle mask; requester i uses slice [i*WIDTH +: WIDTH]
- rpt  input  NREQ*RPTW  repeat count; requester i uses slice [i*RPTW +: RPTW]; toggles = rpt+1
- gnt  output  NREQ  one-hot grant, high for exactly one cycle per accepted request
- busy  output  1  high while a granted job is toggling the bank
- done  output  1  one-cycle pulse after the last toggle of a job
- owner  output  $clog2(NREQ)  index of the current or most recent grantee
- q  output  WIDTH  T-FF bank state

Behaviour:
- Reset (async, rst=1): q=0, gnt=0, busy=0, done=0, owner=0. The RR pointer is set to NREQ-1 so requester 0 has first priority. Any job in flight is discarded immediately; no done pulse is produced.
- FSM states: IDLE, GRANT, TOGGLE.
- IDLE:
  - If req!=0 at a rising edge, pick the first set bit searching from ptr+1 upward, with modulo NREQ wrap.
  - At that edge: latch mask and rpt of the winner into job_mask and job_cnt; set gnt[winner]=1 and owner=winner; set ptr=winner; go to GRANT.
- GRANT (1 cycle):
  - gnt drops to 0 at the next edge.
  - busy=1 from that edge onward.
  - go to TOGGLE.
  - No toggle happens on the GRANT exit edge.
- TOGGLE:
  - On each edge, q <= q ^ job_mask.
  - If job_cnt==0: this is the last toggle; set busy=0 and done=1 for one cycle; return to IDLE.
  - Otherwise decrement job_cnt.
- Latency:
  - req sampled at edge E0 → gnt high for E0..E1.
  - Toggles occur at edges E2 .. E2+rpt.
  - done is high for one cycle after the final toggle edge.
- Back-to-back: IDLE can grant on the same edge at which done falls, so a new gnt coincides with done low again. Minimum job period is rpt+3 cycles.
- Inputs are sampled only at the grant edge. Changes to mask or rpt of the active or other requesters during a job have no effect on that job.
- A requester that drops req before being granted is simply skipped. Requests are not queued.
- Simultaneous requests: exactly one grant per arbitration, in RR order. A requester cannot win twice while another requester is continuously requesting.
- mask=0: the job still runs rpt+1 cycles, q is unchanged, and done pulses.
- rpt=all-ones: 2^RPTW toggles. The counter must not wrap to extend the job.
- Toggling the same bit an even number of times returns it to its start value. The bench relies on this.

Optional Feature:
- Macro TFF_SCHED_PRIO_EN.
- Defined: requester 0 has fixed highest priority. If req[0]=1 at an arbitration edge it wins regardless of ptr. The pointer is not updated when requester 0 wins. The others remain round-robin among themselves.
- Undefined: pure round-robin for all requesters, as described above.

Test Plan:
- Reset then single request: req=4'b0001, mask0=8'h0F, rpt0=0 → gnt=0001 for 1 cycle; q=8'h0F at E2; done at E2..E3; busy low afterwards.
- Repeat count: req0, mask0=8'h01, rpt0=3 → 4 toggles on consecutive edges; q[0] sequence 1,0,1,0; final q=8'h00; single done pulse.
- Round-robin: req=4'b1111 held, rpt=0, distinct masks 01/02/04/08 → grant order 0,1,2,3,0; final q after 4 jobs = 8'h0F. With TFF_SCHED_PRIO_EN, grants go 0,0,0,...
- Back-to-back: req=4'b0011 held, rpt=1 → second gnt on the same edge done deasserts; no idle cycle between jobs.
- Reset mid-job: req2, mask=8'hFF, rpt=7; assert rst after 3 toggles → q=0, busy=0, gnt=0, no done. After release, the next req0 is granted first.
- Input change during job: start job with mask1=8'hAA, then change mask1 to 8'h55 mid-job → toggles continue with 8'hAA only.
